// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit word out MSB first,
// REPEAT times back to back, then pulses DONE for one cycle.
module pattern_tx #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] PAT_IN,
   input  logic [CNT_W-1:0] REPEAT,
   output logic             OUT,
   output logic             VALID,
   output logic             BUSY,
   output logic             DONE
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] FIN   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [BW-1:0]    bitCnt_q, bitCnt_d;
   logic [CNT_W-1:0] repCnt_q, repCnt_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      pat_d    = pat_q;
      bitCnt_d = bitCnt_q;
      repCnt_d = repCnt_q;
      out_d    = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               shift_d  = PAT_IN;
               pat_d    = PAT_IN;
               bitCnt_d = '0;
               repCnt_d = REPEAT;
               busy_d   = 1'b1;
               if (REPEAT != '0) begin
                  state_d = SHIFT;
                  out_d   = PAT_IN[WIDTH-1];
                  valid_d = 1'b1;
               end else begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            if (bitCnt_q == LAST_BIT) begin
               if (repCnt_q == ONE_REP) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  // Reload the saved word so the next copy follows with no gap.
                  repCnt_d = repCnt_q - ONE_REP;
                  bitCnt_d = '0;
                  shift_d  = pat_q;
                  out_d    = pat_q[WIDTH-1];
                  valid_d  = 1'b1;
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
               shift_d  = shift_q << 1;
               out_d    = shift_q[WIDTH-2];
               valid_d  = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         pat_q    <= '0;
         bitCnt_q <= '0;
         repCnt_q <= '0;
         out_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         pat_q    <= pat_d;
         bitCnt_q <= bitCnt_d;
         repCnt_q <= repCnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign OUT   = out_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: inputs change and outputs are sampled 1 time
// unit after each rising edge, so every sample shows the flops just updated.
module tb_pattern_tx;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] patIn;
   logic [3:0] repeatCnt;
   logic       outSig;
   logic       validSig;
   logic       busySig;
   logic       doneSig;

   int total = 0;
   int bad   = 0;

   pattern_tx #(.WIDTH(4), .CNT_W(4)) dut (
      .CLK    (clk),
      .RESET  (reset),
      .START  (start),
      .PAT_IN (patIn),
      .REPEAT (repeatCnt),
      .OUT    (outSig),
      .VALID  (validSig),
      .BUSY   (busySig),
      .DONE   (doneSig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] rep);
      patIn     = pat;
      repeatCnt = rep;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      patIn = 4'b1111;
      repeatCnt = 4'd1;
      tick();
      tick();
      total++;
      if ({outSig, validSig, busySig, doneSig} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b want=0000", {outSig, validSig, busySig, doneSig});
      end
      // START seen only on reset edges must not launch a transfer afterwards.
      reset = 1'b0;
      start = 1'b0;
      tick();
      total++;
      if ({validSig, busySig, doneSig} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL reset_start_discarded got=%b want=000", {validSig, busySig, doneSig});
      end
   endtask

   task automatic test_single();
      logic [3:0] pat;
      pat = 4'b1010;
      applyStimulus(pat, 4'd1);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({validSig, outSig, busySig, doneSig} !== {1'b1, pat[3-i], 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL single_bit%0d got vobd=%b want=%b", i,
                     {validSig, outSig, busySig, doneSig}, {1'b1, pat[3-i], 1'b1, 1'b0});
         end
         tick();
      end
      total++;
      if ({validSig, outSig, busySig, doneSig} !== 4'b0011) begin
         bad++;
         $display("[TB] FAIL single_fin got vobd=%b want=0011", {validSig, outSig, busySig, doneSig});
      end
      tick();
      total++;
      if ({validSig, outSig, busySig, doneSig} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL single_idle got vobd=%b want=0000", {validSig, outSig, busySig, doneSig});
      end
   endtask

   task automatic test_repeat3();
      logic [3:0] pat;
      pat = 4'b1010;
      applyStimulus(pat, 4'd3);
      for (int i = 0; i < 12; i++) begin
         total++;
         if ({validSig, outSig, doneSig} !== {1'b1, pat[3-(i%4)], 1'b0}) begin
            bad++;
            $display("[TB] FAIL repeat3_bit%0d got vod=%b want=%b", i,
                     {validSig, outSig, doneSig}, {1'b1, pat[3-(i%4)], 1'b0});
         end
         tick();
      end
      total++;
      if ({validSig, doneSig} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL repeat3_fin got vd=%b want=01", {validSig, doneSig});
      end
      tick();
      total++;
      if ({validSig, doneSig, busySig} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL repeat3_single_done got vdb=%b want=000", {validSig, doneSig, busySig});
      end
   endtask

   task automatic test_repeat0();
      applyStimulus(4'b1111, 4'd0);
      total++;
      if ({validSig, outSig, busySig, doneSig} !== 4'b0011) begin
         bad++;
         $display("[TB] FAIL repeat0_fin got vobd=%b want=0011", {validSig, outSig, busySig, doneSig});
      end
      tick();
      total++;
      if ({validSig, busySig, doneSig} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL repeat0_after got vbd=%b want=000", {validSig, busySig, doneSig});
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] expStream;
      expStream = 8'b11001100;
      applyStimulus(4'b1100, 4'd2);
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({validSig, outSig} !== {1'b1, expStream[7-i]}) begin
            bad++;
            $display("[TB] FAIL ignore_bit%0d got vo=%b want=%b", i, {validSig, outSig}, {1'b1, expStream[7-i]});
         end
         if (i == 2) begin
            start     = 1'b1;
            patIn     = 4'b0011;
            repeatCnt = 4'd1;
         end
         if (i == 5) start = 1'b0;
         tick();
      end
      total++;
      if ({validSig, doneSig} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL ignore_fin got vd=%b want=01", {validSig, doneSig});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [3:0] pat;
      applyStimulus(4'b1010, 4'd2);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({outSig, validSig, busySig, doneSig} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL midreset_outputs got=%b want=0000", {outSig, validSig, busySig, doneSig});
      end
      tick();
      total++;
      if ({validSig, busySig, doneSig} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL midreset_no_done got vbd=%b want=000", {validSig, busySig, doneSig});
      end
      pat = 4'b0110;
      applyStimulus(pat, 4'd1);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({validSig, outSig} !== {1'b1, pat[3-i]}) begin
            bad++;
            $display("[TB] FAIL midreset_fresh_bit%0d got vo=%b want=%b", i, {validSig, outSig}, {1'b1, pat[3-i]});
         end
         tick();
      end
      total++;
      if (doneSig !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midreset_fresh_done got=%b want=1", doneSig);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      int p;
      pat = 4'b1010;
      patIn = pat;
      repeatCnt = 4'd1;
      start = 1'b1;
      tick();
      // Each transfer occupies 4 data cycles, one FIN cycle and one idle cycle.
      for (int i = 0; i < 12; i++) begin
         p = i % 6;
         total++;
         if ({validSig, outSig, doneSig, busySig} !==
             {(p < 4), (p < 4) ? pat[3-p] : 1'b0, (p == 4), (p < 5)}) begin
            bad++;
            $display("[TB] FAIL b2b_cycle%0d got vodb=%b want=%b", i, {validSig, outSig, doneSig, busySig},
                     {(p < 4), (p < 4) ? pat[3-p] : 1'b0, (p == 4), (p < 5)});
         end
         if (i == 11) start = 1'b0;
         tick();
      end
      total++;
      if ({validSig, busySig} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL b2b_stop got vb=%b want=00", {validSig, busySig});
      end
   endtask

   task automatic test_max_repeat();
      logic [3:0] pat;
      pat = 4'b1001;
      applyStimulus(pat, 4'd15);
      for (int i = 0; i < 60; i++) begin
         total++;
         if ({validSig, outSig} !== {1'b1, pat[3-(i%4)]}) begin
            bad++;
            $display("[TB] FAIL maxrep_bit%0d got vo=%b want=%b", i, {validSig, outSig}, {1'b1, pat[3-(i%4)]});
         end
         tick();
      end
      total++;
      if ({validSig, doneSig} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL maxrep_fin got vd=%b want=01", {validSig, doneSig});
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      patIn = '0;
      repeatCnt = '0;
      test_reset();
      test_single();
      test_repeat3();
      test_repeat0();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_max_repeat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of bits per pattern word (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 4: width of the repeat-count input.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port START, input, 1 bit: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port PAT_IN, input, WIDTH bits: pattern word, sent MSB first (e.g. 4'b1010).
REQ-007 SHALL have port REPEAT, input, CNT_W bits: number of back-to-back pattern copies to send.
REQ-008 SHALL have port OUT, output, 1 bit: serial data bit.
REQ-009 SHALL have port VALID, output, 1 bit: OUT carries a pattern bit this cycle.
REQ-010 SHALL have port BUSY, output, 1 bit: transfer in progress; START is ignored.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-013 SHALL implement the FSM states IDLE, SHIFT and FIN.
REQ-014 In IDLE with START=1 at a rising edge, SHALL latch PAT_IN into a shift register and REPEAT into a repeat counter.
REQ-015 On that same edge (REQ-014), if REPEAT!=0 SHALL enter SHIFT; if REPEAT==0 SHALL enter FIN directly, and no bits are sent.
REQ-016 SHALL present the first bit (PAT_IN[WIDTH-1]) on OUT with VALID=1 in the cycle immediately after the START edge (latency 1).
REQ-017 In SHIFT, SHALL present one bit per cycle, MSB to LSB, using a bit counter that runs 0..WIDTH-1.
REQ-018 After the LSB, if copies remain, SHALL reload the latched pattern with no gap cycle, so that the bit stream is continuous.
REQ-019 SHALL keep VALID=1 for exactly WIDTH*REPEAT consecutive cycles.
REQ-020 After the last bit of the last copy, SHALL enter FIN.
REQ-021 FIN SHALL last one cycle with DONE=1, VALID=0 and OUT=0, and SHALL then return to IDLE.
REQ-022 SHALL hold BUSY=1 in SHIFT and FIN, and BUSY=0 in IDLE.
REQ-023 SHALL ignore START while BUSY=1; no queuing, no restart.
REQ-024 A START in the IDLE cycle following FIN SHALL be accepted normally, giving a minimum spacing of one idle cycle between transfers.
REQ-025 SHALL make changes on PAT_IN and REPEAT after the START edge have no effect on the transfer in progress.
REQ-026 SHALL force OUT=0 whenever VALID=0.
REQ-027 SHALL treat REPEAT as unsigned, so that the maximum 2^CNT_W-1 copies are sent without wrap of the repeat counter.

Reset
REQ-028 With RESET=1 at a rising edge, SHALL enter IDLE and clear the shift register and both counters.
REQ-029 With RESET=1 at a rising edge, SHALL set OUT=0, VALID=0, BUSY=0 and DONE=0.
REQ-030 RESET SHALL take priority over START and over any state, including mid-transfer; the aborted transfer produces no DONE.
REQ-031 START sampled on the edge where RESET=1 SHALL be discarded.
REQ-032 The first accepted START SHALL be on an edge where RESET=0.

Verification
REQ-033 Bench SHALL cover: PAT_IN=1010, REPEAT=1, START pulse -> OUT=1,0,1,0 on 4 cycles with VALID=1 -> DONE=1 next cycle -> BUSY=0 after.
REQ-034 Bench SHALL cover: PAT_IN=1010, REPEAT=3 -> 12 continuous VALID cycles, OUT=101010101010, single DONE pulse.
REQ-035 Bench SHALL cover: REPEAT=0, START -> no VALID; DONE=1 in cycle after START edge; BUSY=1 for that cycle only.
REQ-036 Bench SHALL cover: PAT_IN=1100, REPEAT=2; START re-pulsed and PAT_IN changed to 0011 at bit 3 -> stream stays 11001100, no restart.
REQ-037 Bench SHALL cover: RESET=1 asserted during bit 2 of a REPEAT=2 transfer -> next cycle all outputs 0, IDLE, no DONE; fresh START then sends full pattern.
REQ-038 Bench SHALL cover: START held high continuously with REPEAT=1, PAT_IN=1010 -> transfers repeat with exactly one idle cycle between each FIN and the next first bit.
